// File: rtl/maze_ram_arbiter.sv
// Maze cell RAM arbiter: shares one single-port RAM between the VGA cell fetch
// path (priority, fronted by a one-entry last-cell cache) and game logic
// (maze writes, collision reads), with a starvation guard for game logic.
module maze_ram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 4,
    parameter int unsigned STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    output logic              vga_drop,
    input  logic              game_req,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic              game_gnt,
    output logic [DATA_W-1:0] game_rdata,
    output logic              game_rvalid,
    input  logic              cache_flush,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic              cache_valid_q, cache_valid_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [DATA_W-1:0] cache_data_q, cache_data_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    // In-flight state for the cycle after an access
    logic              vga_hit_q, vga_miss_q, vga_drop_q, game_rd_q;
    logic [ADDR_W-1:0] miss_addr_q;
    logic [DATA_W-1:0] hit_data_q;

    logic              eff_valid;
    logic [ADDR_W-1:0] eff_addr;
    logic [DATA_W-1:0] eff_data;
    logic              hit, vga_miss, force_game, grant_game, grant_vga;

    // Hit detection and arbitration. A fill in progress (miss issued last cycle)
    // already counts as cached, so back-to-back fetches of one cell use the RAM once.
    always_comb begin
        eff_valid  = cache_valid_q | vga_miss_q;
        eff_addr   = vga_miss_q ? miss_addr_q : cache_addr_q;
        eff_data   = vga_miss_q ? ram_rdata : cache_data_q;
        hit        = vga_req & eff_valid & (vga_addr == eff_addr);
        vga_miss   = vga_req & ~hit;
        force_game = vga_miss & game_req & (starve_cnt_q == CNT_MAX);
        grant_game = ~reset & (force_game | (game_req & ~vga_miss));
        grant_vga  = ~reset & vga_miss & ~force_game;
    end

    // RAM port and grant outputs
    always_comb begin
        game_gnt  = grant_game;
        ram_en    = grant_game | grant_vga;
        ram_we    = grant_game & game_we;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_game) begin
            ram_addr = game_addr;
        end else if (grant_vga) begin
            ram_addr = vga_addr;
        end
        if (grant_game && game_we) begin
            ram_wdata = game_wdata;
        end
    end

    // Read-return outputs, zero when not valid
    always_comb begin
        vga_rvalid  = vga_hit_q | vga_miss_q;
        vga_drop    = vga_drop_q;
        game_rvalid = game_rd_q;
        game_rdata  = game_rd_q ? ram_rdata : '0;
        vga_rdata   = '0;
        if (vga_hit_q) begin
            vga_rdata = hit_data_q;
        end else if (vga_miss_q) begin
            vga_rdata = ram_rdata;
        end
    end

    // Cache next state: fill, then write coherence (write beats fill), then flush
    always_comb begin
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
        cache_data_d  = cache_data_q;
        if (vga_miss_q) begin
            cache_valid_d = 1'b1;
            cache_addr_d  = miss_addr_q;
            cache_data_d  = ram_rdata;
        end
        if (grant_game && game_we && (game_addr == cache_addr_d)) begin
            cache_data_d = game_wdata;
        end
        if (cache_flush) begin
            cache_valid_d = 1'b0;
        end
    end

    // Starvation counter: counts cycles a game request waits, saturating
    always_comb begin
        starve_cnt_d = '0;
        if (game_req && !grant_game) begin
            starve_cnt_d = (starve_cnt_q == CNT_MAX) ? starve_cnt_q : starve_cnt_q + 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            starve_cnt_q  <= '0;
            vga_hit_q     <= 1'b0;
            vga_miss_q    <= 1'b0;
            vga_drop_q    <= 1'b0;
            game_rd_q     <= 1'b0;
            miss_addr_q   <= '0;
            hit_data_q    <= '0;
        end else begin
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
            cache_data_q  <= cache_data_d;
            starve_cnt_q  <= starve_cnt_d;
            vga_hit_q     <= hit;
            vga_miss_q    <= grant_vga;
            vga_drop_q    <= force_game;
            game_rd_q     <= grant_game & ~game_we;
            miss_addr_q   <= vga_addr;
            // Sampled in the hit cycle, so a coincident write shows up one cycle later
            hit_data_q    <= eff_data;
        end
    end

endmodule

// File: tb/tb_maze_ram_arbiter.sv
// Bench for maze_ram_arbiter: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the cache and RAM.
module tb_maze_ram_arbiter;

    localparam int STARVE_MAX = 15;

    logic       clk, reset;
    logic       vga_req, vga_rvalid, vga_drop;
    logic [9:0] vga_addr, game_addr, ram_addr;
    logic [3:0] vga_rdata, game_wdata, game_rdata, ram_wdata, ram_rdata;
    logic       game_req, game_we, game_gnt, game_rvalid, cache_flush;
    logic       ram_en, ram_we;

    maze_ram_arbiter #(.ADDR_W(10), .DATA_W(4), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_rdata(vga_rdata),
        .vga_rvalid(vga_rvalid), .vga_drop(vga_drop),
        .game_req(game_req), .game_we(game_we), .game_addr(game_addr),
        .game_wdata(game_wdata), .game_gnt(game_gnt), .game_rdata(game_rdata),
        .game_rvalid(game_rvalid), .cache_flush(cache_flush),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM
    logic [3:0] mem [1024];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    // Reference model: what VGA "sees" as cached, the true memory contents,
    // the game wait count, and the values due on the next cycle.
    logic [3:0] m_mem [1024];
    bit         m_cv;
    logic [9:0] m_ca;
    logic [3:0] m_cd;
    int         m_cnt;
    bit         x_vv, x_drop, x_gv;
    logic [3:0] x_vd, x_gd;

    int n_checks = 0;
    int n_fail   = 0;
    bit last_gnt, last_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_cv = 0; m_cnt = 0; m_ca = '0; m_cd = '0;
        x_vv = 0; x_drop = 0; x_gv = 0; x_vd = '0; x_gd = '0;
    endtask

    // One clock cycle with the inputs currently driven: check at negedge, advance model.
    task automatic step();
        bit hit, vmiss, frc, eg, ev;
        @(negedge clk);
        hit   = vga_req && m_cv && (vga_addr == m_ca);
        vmiss = vga_req && !hit;
        frc   = vmiss && game_req && (m_cnt == STARVE_MAX);
        eg    = frc || (game_req && !vmiss);
        ev    = vmiss && !frc;
        last_gnt = game_gnt;
        last_en  = ram_en;
        chk("game_gnt", 32'(game_gnt), 32'(eg));
        chk("ram_en", 32'(ram_en), 32'(eg || ev));
        chk("ram_we", 32'(ram_we), 32'(eg && game_we));
        if (eg || ev) chk("ram_addr", 32'(ram_addr), 32'(eg ? game_addr : vga_addr));
        if (eg && game_we) chk("ram_wdata", 32'(ram_wdata), 32'(game_wdata));
        chk("vga_rvalid", 32'(vga_rvalid), 32'(x_vv));
        chk("vga_drop", 32'(vga_drop), 32'(x_drop));
        if (x_vv) chk("vga_rdata", 32'(vga_rdata), 32'(x_vd));
        chk("game_rvalid", 32'(game_rvalid), 32'(x_gv));
        if (x_gv) chk("game_rdata", 32'(game_rdata), 32'(x_gd));
        x_vv   = vga_req && !frc;
        x_vd   = hit ? m_cd : m_mem[vga_addr];
        x_drop = frc;
        x_gv   = eg && !game_we;
        x_gd   = m_mem[game_addr];
        m_cnt  = (game_req && !eg) ? ((m_cnt < STARVE_MAX) ? m_cnt + 1 : m_cnt) : 0;
        if (cache_flush) m_cv = 0;
        if (ev) begin
            m_cv = 1; m_ca = vga_addr; m_cd = m_mem[vga_addr];
        end
        if (eg && game_we) begin
            m_mem[game_addr] = game_wdata;
            if (game_addr == m_ca) m_cd = game_wdata;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [3:0] v;
        int en_cnt, gi;
        for (int i = 0; i < 1024; i++) begin
            v = 4'($urandom);
            mem[i] <= v;
            m_mem[i] = v;
        end
        mem[5] <= 4'h3; m_mem[5] = 4'h3;
        mem[9] <= 4'hA; m_mem[9] = 4'hA;
        mreset();

        // Reset state, with requests active to show grants are held off
        reset = 1'b1; vga_req = 1'b1; vga_addr = 10'd5; game_req = 1'b1; game_we = 1'b1;
        game_addr = 10'd9; game_wdata = 4'h1; cache_flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_game_gnt", 32'(game_gnt), 0);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
        chk("rst_vga_drop", 32'(vga_drop), 0);
        chk("rst_vga_rdata", 32'(vga_rdata), 0);
        chk("rst_game_rvalid", 32'(game_rvalid), 0);
        chk("rst_game_rdata", 32'(game_rdata), 0);
        reset = 1'b0; vga_req = 1'b0; game_req = 1'b0;
        @(posedge clk);
        #1;

        // 1: repeated fetch of one cell uses the RAM once
        vga_req = 1'b1; vga_addr = 10'd5; en_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            en_cnt += int'(last_en);
            chk("t1_vga_rvalid", 32'(vga_rvalid), 1);
            chk("t1_vga_rdata", 32'(vga_rdata), 3);
        end
        chk("t1_ram_en_count", 32'(en_cnt), 1);

        // 2: game read while VGA is served from cache
        game_req = 1'b1; game_we = 1'b0; game_addr = 10'd9;
        step();
        chk("t2_gnt", 32'(last_gnt), 1);
        chk("t2_game_rvalid", 32'(game_rvalid), 1);
        chk("t2_game_rdata", 32'(game_rdata), 32'hA);
        chk("t2_vga_rdata", 32'(vga_rdata), 3);
        game_req = 1'b0;

        // 3: starvation guard under continuous VGA misses, twice in a row
        for (int r = 0; r < 2; r++) begin
            gi = -1;
            for (int i = 0; i < 40; i++) begin
                vga_addr = 10'(100 + 100 * r + i);
                game_req = 1'b1;
                step();
                if (last_gnt) begin
                    gi = i;
                    break;
                end
            end
            chk("t3_grant_cycle", 32'(gi), 15);
            chk("t3_vga_drop", 32'(vga_drop), 1);
            chk("t3_no_rvalid", 32'(vga_rvalid), 0);
        end
        game_req = 1'b0;

        // 4: write coherence with a coincident hit
        vga_addr = 10'd5;
        step();
        step();
        game_req = 1'b1; game_we = 1'b1; game_addr = 10'd5; game_wdata = 4'h7;
        step();
        chk("t4_gnt", 32'(last_gnt), 1);
        chk("t4_stale_hit", 32'(vga_rdata), 3);
        game_req = 1'b0;
        #1;
        chk("t4_no_vga_ram", 32'(ram_en), 0);
        step();
        chk("t4_new_hit", 32'(vga_rdata), 7);
        chk("t4_ram", 32'(mem[5]), 7);

        // 5: flush, and flush coincident with a fill
        vga_req = 1'b0; cache_flush = 1'b1;
        step();
        cache_flush = 1'b0; vga_req = 1'b1;
        #1;
        chk("t5_miss_en", 32'(ram_en), 1);
        chk("t5_miss_addr", 32'(ram_addr), 5);
        step();
        vga_req = 1'b0; cache_flush = 1'b1;
        step();
        cache_flush = 1'b0; vga_req = 1'b1;
        #1;
        chk("t5_fill_flush_miss", 32'(ram_en), 1);
        step();

        // 6: reset right after a game read grant
        vga_req = 1'b0; game_req = 1'b1; game_we = 1'b0; game_addr = 10'd9;
        #1;
        chk("t6_gnt", 32'(game_gnt), 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(game_gnt), 0);
        chk("t6_async_en", 32'(ram_en), 0);
        chk("t6_async_vga_rvalid", 32'(vga_rvalid), 0);
        mreset();
        @(posedge clk);
        #1;
        chk("t6_game_rvalid", 32'(game_rvalid), 0);
        game_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic; a game request is held until granted
        last_gnt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!game_req || last_gnt) begin
                game_req   = ($urandom_range(0, 2) != 0);
                game_we    = 1'($urandom);
                game_addr  = 10'($urandom_range(0, 15));
                game_wdata = 4'($urandom);
            end
            vga_req = ($urandom_range(0, 3) != 0);
            if ((c % 300) < 40) vga_addr = 10'($urandom_range(0, 1023));
            else                vga_addr = 10'($urandom_range(0, 15));
            cache_flush = ($urandom_range(0, 31) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
